// File: rtl/exp_neg_seq_pkg.sv
// Shared types and constant helpers for the e^-x evaluator.
// Holds the FSM encoding and the Q-format reciprocal table generator.
package exp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HORNER,
        SQUARE,
        FIN,
        DONE
    } state_t;

    localparam int MAX_TERMS = 15;

    function automatic logic [63:0] one(input int frac);
        return 64'd1 << frac;
    endfunction

    // round(2^frac / k)
    function automatic logic [63:0] recip(input int k, input int frac);
        return (one(frac) + 64'(k / 2)) / 64'(k);
    endfunction

endpackage

// File: rtl/exp_neg_seq_if.sv
// Operand/result valid-ready bundle for exp_neg_seq.
// slave is the evaluator side, master the producer/consumer side.
interface exp_neg_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic signed [DATA_WIDTH-1:0] x_i;
    logic                         in_valid_i;
    logic                         in_ready_o;
    logic signed [DATA_WIDTH-1:0] y_o;
    logic                         sat_o;
    logic                         out_valid_o;
    logic                         out_ready_i;

    modport slave (
        input  x_i, in_valid_i, out_ready_i,
        output in_ready_o, y_o, sat_o, out_valid_o
    );

    modport master (
        output x_i, in_valid_i, out_ready_i,
        input  in_ready_o, y_o, sat_o, out_valid_o
    );
endinterface

// File: rtl/exp_neg_seq_fx_mul.sv
// Signed Q-format multiply: full-width product, arithmetic shift by
// FRAC_BITS (floor), low DATA_WIDTH bits kept.
module fx_mul #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    output logic signed [DATA_WIDTH-1:0] o_p
);
    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] w_prod;
    logic                 w_unused;

    assign w_prod   = PW'(i_a) * PW'(i_b);
    assign o_p      = w_prod[FRAC_BITS +: DATA_WIDTH];
    assign w_unused = ^w_prod;
endmodule

// File: rtl/exp_neg_seq.sv
// Sequential e^-x: Horner Taylor series on x/2^SQ_STEPS, then
// SQ_STEPS squarings; one operand in flight, valid/ready both sides.
module exp_neg_seq
    import exp_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FRAC_BITS  = 16,
    parameter int                    TERMS      = 10,
    parameter int                    SQ_STEPS   = 2,
    parameter logic [DATA_WIDTH-1:0] X_MAX      = DATA_WIDTH'(32'h0008_0000)
) (
    input logic          clk_i,
    input logic          rst_ni,
    exp_neg_seq_if.slave bus
);
    if (TERMS < 1 || TERMS > MAX_TERMS) begin : g_bad_terms
        $error("exp_neg_seq: TERMS out of range");
    end
    if (SQ_STEPS < 0 || SQ_STEPS > 4) begin : g_bad_sq
        $error("exp_neg_seq: SQ_STEPS out of range");
    end
    if (FRAC_BITS >= DATA_WIDTH - 1) begin : g_bad_frac
        $error("exp_neg_seq: FRAC_BITS too large");
    end

    localparam logic signed [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(one(FRAC_BITS));

    state_t                       r_state;
    logic signed [DATA_WIDTH-1:0] r_r;
    logic signed [DATA_WIDTH-1:0] r_acc;
    logic        [3:0]            r_k;
    logic        [2:0]            r_sq;
    logic signed [DATA_WIDTH-1:0] r_y;
    logic                         r_sat;
    logic                         r_out_valid;
    logic                         r_in_ready;

    logic        [DATA_WIDTH-1:0] w_recip [MAX_TERMS+1];
    logic signed [DATA_WIDTH-1:0] w_a;
    logic signed [DATA_WIDTH-1:0] w_p1;
    logic signed [DATA_WIDTH-1:0] w_p2;

    for (genvar g = 0; g <= MAX_TERMS; g++) begin : g_recip
        if (g == 0) begin : g_zero
            assign w_recip[g] = '0;
        end else begin : g_val
            assign w_recip[g] = DATA_WIDTH'(recip(g, FRAC_BITS));
        end
    end

    // First multiplier serves r*acc in HORNER and acc*acc in SQUARE
    assign w_a = (r_state == SQUARE) ? r_acc : r_r;

    fx_mul #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_a (
        .i_a (w_a),
        .i_b (r_acc),
        .o_p (w_p1)
    );

    fx_mul #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_b (
        .i_a (w_p1),
        .i_b (w_recip[r_k]),
        .o_p (w_p2)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_r         <= '0;
            r_acc       <= '0;
            r_k         <= '0;
            r_sq        <= '0;
            r_y         <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_in_ready && bus.in_valid_i) begin
                        r_in_ready <= 1'b0;
                        if (bus.x_i[DATA_WIDTH-1]) begin
                            r_y         <= ONE;
                            r_sat       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else if (bus.x_i > $signed(X_MAX)) begin
                            r_y         <= '0;
                            r_sat       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_r     <= bus.x_i >>> SQ_STEPS;
                            r_acc   <= ONE;
                            r_k     <= 4'(TERMS);
                            r_sat   <= 1'b0;
                            r_state <= HORNER;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                HORNER: begin
                    r_acc <= ONE - w_p2;
                    r_k   <= r_k - 4'd1;
                    if (r_k == 4'd1) begin
                        r_sq    <= 3'(SQ_STEPS);
                        r_state <= (SQ_STEPS > 0) ? SQUARE : FIN;
                    end
                end
                SQUARE: begin
                    r_acc <= w_p1;
                    r_sq  <= r_sq - 3'd1;
                    if (r_sq == 3'd1) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    if (r_acc < 0) begin
                        r_y   <= '0;
                        r_sat <= 1'b1;
                    end else if (r_acc > ONE) begin
                        r_y   <= ONE;
                        r_sat <= 1'b1;
                    end else begin
                        r_y <= r_acc;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = r_in_ready;
    assign bus.out_valid_o = r_out_valid;
    assign bus.y_o         = r_y;
    assign bus.sat_o       = r_sat;
endmodule

// File: tb/tb_exp_neg_seq.sv
// Scoreboard bench for exp_neg_seq: directed operands, expected
// results queued on accept and checked by a monitor on output handshake.
module tb_exp_neg_seq;
    logic clk;
    logic rst_ni;

    exp_neg_seq_if #(.DATA_WIDTH(32)) bus ();

    exp_neg_seq #(
        .DATA_WIDTH (32),
        .FRAC_BITS  (16),
        .TERMS      (10),
        .SQ_STEPS   (2),
        .X_MAX      (32'h0008_0000)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] y;
        int          tol;
        logic        sat;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int lat = 0;
    bit seen = 0;
    int n_acc = 0;
    int n_sent = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp, input int tol);
        int d;
        n_cmp++;
        d = $signed(act) - $signed(exp);
        if (d < 0) d = -d;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (tol %0d)", nm, act, exp, tol);
        end
    endtask

    always @(negedge clk) begin
        if (rst_ni && bus.in_valid_i && bus.in_ready_o) n_acc++;
    end

    // Monitor: latency measured at first valid, data checked on handshake
    always @(negedge clk) begin
        if (rst_ni) begin
            if (bus.out_valid_o && !seen) begin
                seen = 1;
                lat = cyc - last_acc;
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got %h want none", bus.y_o);
                end else begin
                    mon_e = sb.pop_front();
                    chk("y", bus.y_o, mon_e.y, mon_e.tol);
                    chk("sat", {31'b0, bus.sat_o}, {31'b0, mon_e.sat}, 0);
                    chk("latency", lat, mon_e.lat, 0);
                end
                seen = 0;
            end
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] ey,
                        input int tol, input logic es, input int el,
                        input bit hold);
        exp_t e;
        bit ok;
        ok = 0;
        bus.x_i = x;
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.in_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept want accept for x=%h", x);
        end else begin
            n_sent++;
            e.y = ey;
            e.tol = tol;
            e.sat = es;
            e.lat = el;
            sb.push_back(e);
            last_acc = cyc;
        end
        @(posedge clk);
        #1;
        if (!hold) bus.in_valid_i = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] cap_y;
    logic        cap_s;
    int          stale;
    bit          got;

    initial begin
        rst_ni = 1'b0;
        bus.x_i = '0;
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, bus.in_ready_o}, 32'd0, 0);
        chk("rst_out_valid", {31'b0, bus.out_valid_o}, 32'd0, 0);
        chk("rst_y", bus.y_o, 32'd0, 0);
        chk("rst_sat", {31'b0, bus.sat_o}, 32'd0, 0);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", {31'b0, bus.in_ready_o}, 32'd1, 0);

        // Directed operands, one at a time
        send(32'h0000_0000, 32'h0001_0000, 0, 1'b0, 14, 1'b0);
        drain();
        send(32'h0001_0000, 32'h0000_5E2D, 8, 1'b0, 14, 1'b0);
        drain();
        send(32'h0000_8000, 32'h0000_9B45, 8, 1'b0, 14, 1'b0);
        drain();
        send(32'hFFFF_0000, 32'h0001_0000, 0, 1'b1, 1, 1'b0);
        drain();
        send(32'h0009_0000, 32'h0000_0000, 0, 1'b1, 1, 1'b0);
        drain();
        send(32'h0008_0000, 32'h0000_0016, 8, 1'b0, 14, 1'b0);
        drain();

        // Backpressure: result held, stray operands ignored
        bus.out_ready_i = 1'b0;
        send(32'h0001_0000, 32'h0000_5E2D, 8, 1'b0, 14, 1'b0);
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid_o) begin
                got = 1;
                break;
            end
        end
        chk("bp_valid_seen", {31'b0, got}, 32'd1, 0);
        cap_y = bus.y_o;
        cap_s = bus.sat_o;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid_i = (i % 3 == 0);
            bus.x_i = 32'h0002_0000;
            @(negedge clk);
            chk("bp_y_stable", bus.y_o, cap_y, 0);
            chk("bp_sat_stable", {31'b0, bus.sat_o}, {31'b0, cap_s}, 0);
            chk("bp_in_ready", {31'b0, bus.in_ready_o}, 32'd0, 0);
            chk("bp_out_valid", {31'b0, bus.out_valid_o}, 32'd1, 0);
        end
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_after", {31'b0, bus.in_ready_o}, 32'd1, 0);
        drain();

        // Back-to-back with in_valid held high
        send(32'h0001_0000, 32'h0000_5E2D, 8, 1'b0, 14, 1'b1);
        send(32'h0002_0000, 32'h0000_22A5, 8, 1'b0, 14, 1'b1);
        send(32'h0003_0000, 32'h0000_0CBF, 8, 1'b0, 14, 1'b0);
        drain();

        // Async reset during HORNER aborts the operand
        send(32'h0000_8000, 32'h0000_9B45, 8, 1'b0, 14, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("abort_out_valid", {31'b0, bus.out_valid_o}, 32'd0, 0);
        chk("abort_in_ready", {31'b0, bus.in_ready_o}, 32'd0, 0);
        chk("abort_y", bus.y_o, 32'd0, 0);
        chk("abort_sat", {31'b0, bus.sat_o}, 32'd0, 0);
        sb.delete();
        seen = 0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready_rel", {31'b0, bus.in_ready_o}, 32'd1, 0);
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid_o) stale++;
        end
        chk("no_stale_result", stale, 32'd0, 0);
        @(posedge clk);
        #1;
        send(32'h0000_8000, 32'h0000_9B45, 8, 1'b0, 14, 1'b0);
        drain();

        chk("accept_count", n_acc, n_sent, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
